// File: rtl/pe_acc_drain.sv
// pe_acc_drain
// ------------
// Read-side drain controller for a PE accumulation buffer. A job walks a
// contiguous, wrapping address range on the buffer read port. Each returned
// word is BATCH signed RES_W lanes. Every lane is rounded (half up), shifted
// right arithmetically and saturated to a signed DATA_W lane. The results are
// presented as a first-word-fall-through valid/ready stream toward writeback.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          one-cycle pulse that begins a job (ignored unless idle)
//   base_addr      first buffer address, sampled on start
//   len            words to drain (0..2^ADDR_W), sampled on start
//   shift          requantization right-shift, sampled on start
//   busy           high from accepted start until done
//   done           one-cycle completion pulse
//   abuf_rd_addr   registered read address to the accumulation buffer
//   abuf_rd_en     registered read strobe
//   abuf_rd_data   read data, valid RD_LAT cycles after abuf_rd_en
//   out_data       requantized word (lane i at [i*DATA_W +: DATA_W])
//   out_valid      stream valid (FIFO non-empty)
//   out_ready      stream ready
//   out_last       marks the final word of the job
module pe_acc_drain #(
  parameter int BATCH      = 4,
  parameter int DATA_W     = 16,
  parameter int RES_W      = 32,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         len,
  input  logic [4:0]              shift,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       abuf_rd_addr,
  output logic                    abuf_rd_en,
  input  logic [BATCH*RES_W-1:0]  abuf_rd_data,
  output logic [BATCH*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = BATCH * DATA_W;
  localparam int ENT_W  = WORD_W + 1;  // {last, data}

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Saturation bounds expressed at the widened requantization width.
  localparam logic signed [RES_W:0] SAT_MAX = (RES_W+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_FIN
  } state_t;

  state_t                 state;
  logic [LEN_W-1:0]       len_q;
  logic [4:0]             shift_q;
  logic [LEN_W-1:0]       issued;
  logic [ADDR_W-1:0]      next_addr;
  logic                   rd_last;

  // Return-path tags, one stage per cycle of buffer latency.
  logic [RD_LAT-1:0]      tag_v;
  logic [RD_LAT-1:0]      tag_last;

  // Output FIFO.
  logic [ENT_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;

  // Reads decided but not yet popped from the FIFO. Bounding this by the
  // FIFO depth guarantees every returning word has a free slot.
  logic [CNT_W-1:0]       occ;

  logic                   issue;
  logic                   issue_last;
  logic                   push;
  logic                   pop;
  logic [WORD_W-1:0]      push_data;
  logic [ENT_W-1:0]       head;

  // Round half up, arithmetic shift, saturate. The extra bit keeps the
  // rounding add from overflowing near the top of the RES_W range.
  function automatic logic [DATA_W-1:0] requant(input logic [RES_W-1:0] x,
                                                input logic [4:0]       sh);
    logic signed [RES_W:0] wide;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] y;
    wide = $signed({x[RES_W-1], x});
    rnd  = '0;
    if (sh != 5'd0) rnd = (RES_W+1)'(1) << (sh - 5'd1);
    y = (wide + rnd) >>> sh;
    if (y > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (y < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return y[DATA_W-1:0];
  endfunction

  assign push      = tag_v[RD_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign head      = fifo_mem[rd_ptr];
  // Outputs read as zero while empty so reset clears them immediately.
  assign out_data  = out_valid ? head[WORD_W-1:0] : '0;
  assign out_last  = out_valid & head[WORD_W];

  // Read issue decision for the next cycle's registered strobe. A pop in the
  // same cycle frees a slot, which keeps a full-rate stream at 1 word/cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state)
      S_IDLE: begin
        issue      = start && (len != '0);
        issue_last = (len == LEN_W'(1));
      end
      S_RUN: begin
        issue      = (issued != len_q) && ((occ < DEPTH_C) || pop);
        issue_last = ((issued + LEN_W'(1)) == len_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < BATCH; i++) begin
      push_data[i*DATA_W +: DATA_W] = requant(abuf_rd_data[i*RES_W +: RES_W], shift_q);
    end
  end

  // Control FSM with registered read-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      abuf_rd_en   <= 1'b0;
      abuf_rd_addr <= '0;
      rd_last      <= 1'b0;
      len_q        <= '0;
      shift_q      <= '0;
      issued       <= '0;
      next_addr    <= '0;
    end else begin
      abuf_rd_en <= issue;
      rd_last    <= issue & issue_last;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= len;
            shift_q <= shift;
            if (len != '0) begin
              state        <= S_RUN;
              busy         <= 1'b1;
              abuf_rd_addr <= base_addr;
              next_addr    <= base_addr + ADDR_W'(1);
              issued       <= LEN_W'(1);
            end else begin
              state  <= S_FIN;
              done   <= 1'b1;
              issued <= '0;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            abuf_rd_addr <= next_addr;
            next_addr    <= next_addr + ADDR_W'(1);
            issued       <= issued + LEN_W'(1);
          end
          if ((issue && issue_last) || (issued == len_q)) state <= S_WAIT;
        end
        S_WAIT: begin
          if (pop && out_last) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return tags, FIFO pointers and the credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v      <= '0;
      tag_last   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      occ        <= '0;
    end else begin
      tag_v[0]    <= abuf_rd_en;
      tag_last[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      unique case ({issue, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; validity comes from the reset pointers
  // and count, and the output is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {tag_last[RD_LAT-1], push_data};
  end

endmodule
